// File: rtl/jtag_tap_sequencer.sv
// JTAG TAP master: turns one IR/DR scan request into the TMS/TDI bit sequence
// on tck, returns captured TDO bits, and owns Test-Logic-Reset entry.
module jtag_tap_sequencer #(
    parameter int unsigned MAX_LEN      = 32,
    parameter int unsigned LEN_W        = $clog2(MAX_LEN + 1),
    parameter int unsigned RESET_CYCLES = 5
) (
    input  logic               tck,
    input  logic               trst,
    input  logic               soft_rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_ir,
    input  logic               cmd_rnw,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               tms,
    output logic               tdi,
    output logic               read_not_write,
    input  logic               tdo,
    output logic               busy
);
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [3:0] {
        TLR_SEQ, GO_IDLE, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RESP
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   count;
    logic [RST_W-1:0]   rst_cnt;
    logic               shift_on;
    logic               soft_pend;
    logic [LEN_W-1:0]   len_q;
    logic               ir_q;
    logic [MAX_LEN-1:0] data_q;
    logic               soft_pend_c;

    // soft_rst is sticky until the sequencer is back in IDLE with no scan in flight
    assign soft_pend_c = soft_pend | soft_rst;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state          <= TLR_SEQ;
            count          <= '0;
            rst_cnt        <= '0;
            shift_on       <= 1'b0;
            soft_pend      <= 1'b0;
            len_q          <= '0;
            ir_q           <= 1'b0;
            data_q         <= '0;
            tms            <= 1'b1;
            tdi            <= 1'b0;
            read_not_write <= 1'b0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_data       <= '0;
            busy           <= 1'b1;
        end else begin
            soft_pend <= soft_pend_c;
            case (state)
                TLR_SEQ: begin
                    if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
                        state   <= GO_IDLE;
                        tms     <= 1'b0;
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                GO_IDLE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= !soft_pend_c;
                end
                IDLE: begin
                    cmd_ready <= !soft_pend_c;
                    if (soft_pend) begin
                        state     <= TLR_SEQ;
                        tms       <= 1'b1;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                        soft_pend <= 1'b0;
                        rst_cnt   <= '0;
                    end else if (cmd_valid && cmd_ready) begin
                        cmd_ready      <= 1'b0;
                        busy           <= 1'b1;
                        read_not_write <= cmd_rnw;
                        len_q          <= cmd_len;
                        ir_q           <= cmd_ir;
                        data_q         <= cmd_data;
                        rsp_data       <= '0;
                        if (cmd_len == '0 || cmd_len > LEN_W'(MAX_LEN)) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state   <= SEL_DR;
                            tms     <= 1'b1;
                            rsp_err <= 1'b0;
                        end
                    end
                end
                SEL_DR: begin
                    state <= ir_q ? SEL_IR : CAPTURE;
                    tms   <= ir_q;
                end
                SEL_IR: begin
                    state <= CAPTURE;
                    tms   <= 1'b0;
                end
                CAPTURE: begin
                    state    <= SHIFT;
                    tms      <= 1'b0;
                    count    <= '0;
                    shift_on <= 1'b0;
                end
                // first SHIFT cycle moves the TAP into Shift; data cycles follow
                SHIFT: begin
                    if (!shift_on) begin
                        shift_on <= 1'b1;
                        tdi      <= data_q[0];
                        tms      <= (len_q == LEN_W'(1));
                    end else begin
                        rsp_data[IDX_W'(count)] <= tdo;
                        if (count == len_q - LEN_W'(1)) begin
                            state    <= EXIT1;
                            tms      <= 1'b1;
                            tdi      <= 1'b0;
                            shift_on <= 1'b0;
                        end else begin
                            count <= count + LEN_W'(1);
                            tdi   <= data_q[IDX_W'(count + LEN_W'(1))];
                            tms   <= (count + LEN_W'(2) == len_q);
                        end
                    end
                end
                EXIT1: begin
                    state <= UPDATE;
                    tms   <= 1'b0;
                end
                UPDATE: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state          <= IDLE;
                        rsp_valid      <= 1'b0;
                        read_not_write <= 1'b0;
                        busy           <= 1'b0;
                        cmd_ready      <= !soft_pend_c;
                    end
                end
                default: begin
                    state   <= TLR_SEQ;
                    tms     <= 1'b1;
                    busy    <= 1'b1;
                    rst_cnt <= '0;
                end
            endcase
        end
    end
endmodule
